// File: rtl/uart_pkg.sv
// Shared UART definitions: default character/line parameters, capture FSM states,
// and the CeilLog2 helper used to size FIFO pointers.
`timescale 1ns/1ps
package uart_pkg;
   localparam int UART_NBIT     = 8;
   localparam int UART_BAUDRATE = 115200;
   localparam int UART_CLK_FREQ = 50_000_000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   function automatic int CeilLog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word-fall-through head; registered count/empty/full.
// A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
`timescale 1ns/1ps
module sync_fifo
   import uart_pkg::*;
#(
   parameter  int W     = 9,
   parameter  int DEPTH = 16,
   localparam int AW    = CeilLog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_nxt;
   logic          push_eff;
   logic          pop_eff;

   assign pop_eff  = pop && !empty;
   assign push_eff = push && (!full || pop_eff);
   assign rdata    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push_eff && !pop_eff)
         count_nxt = count + 1'b1;
      else if (!push_eff && pop_eff)
         count_nxt = count - 1'b1;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (push_eff) wr_ptr <= wr_ptr + 1'b1;
         if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == FULL_CNT);
      end
   end

   always_ff @(posedge clk) begin
      if (push_eff) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/uart_rx_fifo.sv
// Captures each UART receiver byte once, acks it with a one-cycle clr_rx_flag, and
// queues {parity_err, data}; visible one cycle after capture; full FIFO drops and flags overflow.
`timescale 1ns/1ps
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter  int Nbit  = UART_NBIT,
   parameter  int DEPTH = 16,
   localparam int AW    = CeilLog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Rx_flag,
   input  logic [Nbit-1:0] DataRx,
   input  logic            Parity_error,
   output logic            clr_rx_flag,
   input  logic            rd_en,
   output logic [Nbit-1:0] rd_data,
   output logic            rd_perr,
   output logic            empty,
   output logic            full,
   output logic [AW:0]     count,
   output logic            overflow,
   input  logic            ovf_clr,
   output logic            irq
);
   logic [1:0]    state;
   logic          capture;
   logic          accept;
   logic          push;
   logic          drop;
   logic [Nbit:0] head;

   assign capture = (state == ST_IDLE) && Rx_flag;
   assign accept  = !full || (rd_en && !empty);
   assign push    = capture && accept;
   assign drop    = capture && !accept;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         clr_rx_flag <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Rx_flag) begin
                  state       <= ST_ACK;
                  clr_rx_flag <= 1'b1;
               end
            end
            ST_ACK: begin
               state       <= ST_WAIT;
               clr_rx_flag <= 1'b0;
            end
            ST_WAIT: begin
               if (!Rx_flag) state <= ST_IDLE;
            end
            default: begin
               state       <= ST_IDLE;
               clr_rx_flag <= 1'b0;
            end
         endcase
      end
   end

   // A drop in the same cycle as ovf_clr must leave the flag set.
   always_ff @(posedge clk) begin
      if (!reset)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
      else if (ovf_clr)
         overflow <= 1'b0;
   end

   sync_fifo #(
      .W     (Nbit + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata ({Parity_error, DataRx}),
      .pop   (rd_en),
      .rdata (head),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   assign rd_data = head[Nbit-1:0];
   assign rd_perr = head[Nbit];
   assign irq     = !empty;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based model of the buffer.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       Rx_flag;
   logic [7:0] DataRx;
   logic       Parity_error;
   logic       clr_rx_flag;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_perr;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       ovf_clr;
   logic       irq;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [8:0] q[$];
   logic       ovf_m;

   always #5 clk = ~clk;

   uart_rx_fifo #(.Nbit(8), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .Rx_flag      (Rx_flag),
      .DataRx       (DataRx),
      .Parity_error (Parity_error),
      .clr_rx_flag  (clr_rx_flag),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_perr      (rd_perr),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .overflow     (overflow),
      .ovf_clr      (ovf_clr),
      .irq          (irq)
   );

   // Receiver-like handshake: raise the flag, expect the ack one edge later, drop it.
   task automatic send_byte(input logic [7:0] d, input logic pe, input logic oc);
      Rx_flag = 1'b1; DataRx = d; Parity_error = pe; ovf_clr = oc;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      if (q.size() < DEPTH) q.push_back({pe, d});
      else ovf_m = 1'b1;
      tests_run++;
      if (clr_rx_flag !== 1'b1) begin
         tests_failed++; $display("FAIL send_ack: clr_rx_flag=%b expected 1", clr_rx_flag);
      end
      tests_run++;
      if (count !== 5'(q.size())) begin
         tests_failed++; $display("FAIL send_count: count=%0d expected %0d", count, q.size());
      end
      tests_run++;
      if (overflow !== ovf_m) begin
         tests_failed++; $display("FAIL send_ovf: overflow=%b expected %b", overflow, ovf_m);
      end
      Rx_flag = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (clr_rx_flag !== 1'b0) begin
         tests_failed++; $display("FAIL ack_width: clr_rx_flag=%b expected 0", clr_rx_flag);
      end
      @(posedge clk); #1;
   endtask

   task automatic pop_check();
      if (q.size() > 0) begin
         tests_run++;
         if ({rd_perr, rd_data} !== q[0]) begin
            tests_failed++;
            $display("FAIL pop_head: perr/data=%b/%h expected %b/%h", rd_perr, rd_data, q[0][8], q[0][7:0]);
         end
         void'(q.pop_front());
      end
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      tests_run++;
      if (count !== 5'(q.size()) || empty !== (q.size() == 0)) begin
         tests_failed++;
         $display("FAIL pop_count: count=%0d empty=%b expected %0d/%b", count, empty, q.size(), q.size() == 0);
      end
   endtask

   // Capture and pop at the same edge.
   task automatic push_pop(input logic [7:0] d, input logic pe);
      Rx_flag = 1'b1; DataRx = d; Parity_error = pe; rd_en = 1'b1;
      @(posedge clk); #1;
      Rx_flag = 1'b0; rd_en = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
      q.push_back({pe, d});
      tests_run++;
      if (count !== 5'(q.size()) || overflow !== ovf_m || clr_rx_flag !== 1'b1) begin
         tests_failed++;
         $display("FAIL push_pop: count=%0d ovf=%b clr=%b expected %0d/%b/1", count, overflow, clr_rx_flag, q.size(), ovf_m);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; Rx_flag = 1'b1; DataRx = 8'h55; Parity_error = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (clr_rx_flag !== 1'b0 || empty !== 1'b1 || count !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_state: clr=%b empty=%b count=%0d expected 0/1/0", clr_rx_flag, empty, count);
      end
      tests_run++;
      if (full !== 1'b0 || overflow !== 1'b0 || irq !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: full=%b ovf=%b irq=%b expected 0/0/0", full, overflow, irq);
      end
      Rx_flag = 1'b0;
      reset = 1'b1;
      q.delete(); ovf_m = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_byte();
      int pulses;
      pulses = 0;
      Rx_flag = 1'b1; DataRx = 8'hA5; Parity_error = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (clr_rx_flag === 1'b1) pulses++;
      end
      q.push_back({1'b0, 8'hA5});
      tests_run++;
      if (pulses != 1) begin
         tests_failed++; $display("FAIL single_pulses: %0d pulses expected 1", pulses);
      end
      tests_run++;
      if (count !== 5'd1 || rd_data !== 8'hA5 || rd_perr !== 1'b0 || irq !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_head: count=%0d data=%h perr=%b irq=%b expected 1/a5/0/1", count, rd_data, rd_perr, irq);
      end
      Rx_flag = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pop_check();
      tests_run++;
      if (empty !== 1'b1 || irq !== 1'b0) begin
         tests_failed++; $display("FAIL single_drain: empty=%b irq=%b expected 1/0", empty, irq);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0, 1'b0);
      tests_run++;
      if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
         tests_failed++; $display("FAIL fill_full: full=%b count=%0d ovf=%b expected 1/16/0", full, count, overflow);
      end
      send_byte(8'hFF, 1'b0, 1'b0);
      tests_run++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         tests_failed++; $display("FAIL fill_drop: ovf=%b count=%0d expected 1/16", overflow, count);
      end
      ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0; ovf_m = 1'b0;
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++; $display("FAIL ovf_clear: overflow=%b expected 0", overflow);
      end
      send_byte(8'hEE, 1'b1, 1'b1);
      tests_run++;
      if (overflow !== 1'b1) begin
         tests_failed++; $display("FAIL ovf_set_wins: overflow=%b expected 1", overflow);
      end
      ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0; ovf_m = 1'b0;
      while (q.size() > 0) pop_check();
   endtask

   task automatic test_full_simultaneous();
      for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'($urandom), 1'b0);
      push_pop(8'h3C, 1'b0);
      tests_run++;
      if (full !== 1'b1 || overflow !== 1'b0) begin
         tests_failed++; $display("FAIL full_simul: full=%b ovf=%b expected 1/0", full, overflow);
      end
      tests_run++;
      if (q[DEPTH-1] !== {1'b0, 8'h3C}) begin
         tests_failed++; $display("FAIL simul_order: model tail %h expected 03c", q[DEPTH-1]);
      end
      while (q.size() > 0) pop_check();
      push_pop(8'h5A, 1'b1);
      tests_run++;
      if (count !== 5'd1 || rd_data !== 8'h5A || rd_perr !== 1'b1) begin
         tests_failed++; $display("FAIL empty_simul: count=%0d data=%h perr=%b expected 1/5a/1", count, rd_data, rd_perr);
      end
      push_pop(8'hC3, 1'b0);
      tests_run++;
      if (count !== 5'd1 || rd_data !== 8'hC3) begin
         tests_failed++; $display("FAIL one_simul: count=%0d data=%h expected 1/c3", count, rd_data);
      end
      pop_check();
   endtask

   task automatic test_wrap_perr();
      for (int i = 0; i < 40; i++) begin
         send_byte(8'($urandom), 1'(i & 1), 1'b0);
         if (q.size() >= 12 || $urandom_range(0, 1) == 1) pop_check();
      end
      while (q.size() > 0) pop_check();
      tests_run++;
      if (empty !== 1'b1 || overflow !== 1'b0) begin
         tests_failed++; $display("FAIL wrap_end: empty=%b ovf=%b expected 1/0", empty, overflow);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i <= DEPTH; i++) send_byte(8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) pop_check();
      Rx_flag = 1'b1; DataRx = 8'h99; Parity_error = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; Rx_flag = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (empty !== 1'b1 || count !== 5'd0 || clr_rx_flag !== 1'b0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset: empty=%b count=%0d clr=%b ovf=%b expected 1/0/0/0", empty, count, clr_rx_flag, overflow);
      end
      reset = 1'b1;
      q.delete(); ovf_m = 1'b0;
      @(posedge clk); #1;
      send_byte(8'h77, 1'b1, 1'b0);
      pop_check();
   endtask

   initial begin
      reset = 1'b0; Rx_flag = 1'b0; DataRx = '0; Parity_error = 1'b0;
      rd_en = 1'b0; ovf_clr = 1'b0; ovf_m = 1'b0;
      test_reset();
      test_single_byte();
      test_fill_overflow();
      test_full_simultaneous();
      test_wrap_perr();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
